// File: rtl/md_unit.sv
// -----------------------------------------------------------------------------
// md_unit
//   Multiply/divide unit for the E stage of a 5-stage MIPS pipeline.
//   It runs mult/multu/div/divu with a fixed multi-cycle latency, handles
//   mthi/mtlo, and owns the architectural HI/LO registers.
//
//   The 64-bit result is computed combinationally from A/B in the Start cycle
//   and parked in temporaries. A down-counter then models the latency, and the
//   temporaries are committed to HI/LO on the edge where the counter leaves 1.
//   HI/LO therefore stay at their old values while Busy is high.
//
// Ports
//   clk    in   1   rising-edge clock
//   reset  in   1   asynchronous, active-low; clears all state
//   Start  in   1   E-stage instruction is an MD op; qualifies MDop
//   MDop   in   3   1 mult, 2 multu, 3 div, 4 divu, 5 mthi, 6 mtlo; 0/7 none
//   A      in   32  rs operand
//   B      in   32  rt operand
//   Busy   out  1   op in flight, including the Start cycle (combinational)
//   HI     out  32  HI register
//   LO     out  32  LO register
// -----------------------------------------------------------------------------
module md_unit #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        Start,
    input  logic [2:0]  MDop,
    input  logic [31:0] A,
    input  logic [31:0] B,
    output logic        Busy,
    output logic [31:0] HI,
    output logic [31:0] LO
);

    localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CW         = $clog2(MAX_CYCLES + 1);

    localparam logic [2:0] OP_MULT  = 3'd1;
    localparam logic [2:0] OP_MULTU = 3'd2;
    localparam logic [2:0] OP_DIV   = 3'd3;
    localparam logic [2:0] OP_DIVU  = 3'd4;
    localparam logic [2:0] OP_MTHI  = 3'd5;
    localparam logic [2:0] OP_MTLO  = 3'd6;

    localparam logic [CW-1:0] MULT_LOAD = CW'(MULT_CYCLES);
    localparam logic [CW-1:0] DIV_LOAD  = CW'(DIV_CYCLES);

    logic [CW-1:0] cnt_q, cnt_d;
    logic [31:0]   hi_q, hi_d, lo_q, lo_d;
    logic [31:0]   hi_tmp_q, hi_tmp_d, lo_tmp_q, lo_tmp_d;

    logic          is_md_op;
    logic          idle;

    // Arithmetic datapath
    logic [63:0]   prod_s, prod_u;
    logic [31:0]   a_mag, b_mag, q_mag, r_mag;
    logic [31:0]   q_s, r_s, q_u, r_u;
    logic [63:0]   result;

    assign is_md_op = (MDop >= OP_MULT) && (MDop <= OP_DIVU);
    assign idle     = (cnt_q == '0);
    assign Busy     = (Start && is_md_op) || !idle;
    assign HI       = hi_q;
    assign LO       = lo_q;

    always_comb begin
        // Signed product via explicit sign extension to 64 bits; the low
        // 64 bits of the two's-complement product are exact.
        prod_s = {{32{A[31]}}, A} * {{32{B[31]}}, B};
        prod_u = {32'd0, A} * {32'd0, B};

        // Signed division on magnitudes: quotient is truncated toward zero and
        // the remainder follows the dividend's sign. The 0x8000_0000 / -1
        // overflow case falls out naturally (magnitude 0x8000_0000, positive
        // sign, wraps to 0x8000_0000; remainder 0).
        a_mag = A[31] ? (~A + 32'd1) : A;
        b_mag = B[31] ? (~B + 32'd1) : B;
        q_mag = (B == 32'd0) ? 32'd0 : (a_mag / b_mag);
        r_mag = (B == 32'd0) ? 32'd0 : (a_mag % b_mag);
        q_s   = (A[31] ^ B[31]) ? (~q_mag + 32'd1) : q_mag;
        r_s   = A[31] ? (~r_mag + 32'd1) : r_mag;
        q_u   = (B == 32'd0) ? 32'd0 : (A / B);
        r_u   = (B == 32'd0) ? 32'd0 : (A % B);

        result = 64'd0;
        case (MDop)
            OP_MULT:  result = prod_s;
            OP_MULTU: result = prod_u;
            OP_DIV:   result = (B == 32'd0) ? {A, 32'hFFFF_FFFF} : {r_s, q_s};
            OP_DIVU:  result = (B == 32'd0) ? {A, 32'hFFFF_FFFF} : {r_u, q_u};
            default:  result = 64'd0;
        endcase
    end

    // Next-state logic
    always_comb begin
        cnt_d    = cnt_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        hi_tmp_d = hi_tmp_q;
        lo_tmp_d = lo_tmp_q;

        if (!idle) begin
            // In flight: any Start is ignored.
            cnt_d = cnt_q - CW'(1);
            if (cnt_q == CW'(1)) begin
                hi_d = hi_tmp_q;
                lo_d = lo_tmp_q;
            end
        end else if (Start) begin
            case (MDop)
                OP_MULT, OP_MULTU: begin
                    hi_tmp_d = result[63:32];
                    lo_tmp_d = result[31:0];
                    cnt_d    = MULT_LOAD;
                end
                OP_DIV, OP_DIVU: begin
                    hi_tmp_d = result[63:32];
                    lo_tmp_d = result[31:0];
                    cnt_d    = DIV_LOAD;
                end
                OP_MTHI: hi_d = A;
                OP_MTLO: lo_d = A;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q    <= '0;
            hi_q     <= 32'd0;
            lo_q     <= 32'd0;
            hi_tmp_q <= 32'd0;
            lo_tmp_q <= 32'd0;
        end else begin
            cnt_q    <= cnt_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            hi_tmp_q <= hi_tmp_d;
            lo_tmp_q <= lo_tmp_d;
        end
    end

endmodule
